reg_file: RTL
=============

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 32, register and data width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; register count NREGS = 2**ADDR_W (32).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 we  input  1  write enable for the single write port.
REQ-007 waddr  input  ADDR_W  write register index.
REQ-008 wdata  input  DATA_W  write data.
REQ-009 raddr1  input  ADDR_W  read port 1 register index.
REQ-010 raddr2  input  ADDR_W  read port 2 register index.
REQ-011 rdata1  output  DATA_W  read port 1 data.
REQ-012 rdata2  output  DATA_W  read port 2 data.

Function
REQ-013 Write path SHALL demultiplex wdata to exactly one register.
- The target is selected by decoding waddr into a one-hot write strobe, qualified by we.
REQ-014 Write SHALL commit at the rising clk edge when we=1 and rst=0.
- The new value is visible on reads in the following cycle (1-cycle write latency).
REQ-015 When we=0, no register SHALL change.
REQ-016 Register 0 SHALL always read as 0.
- A write with waddr=0 is silently discarded.
REQ-017 Read ports SHALL be combinational, with no latency.
- Each port returns the register selected by raddrN within the same cycle.
REQ-018 Both read ports SHALL operate independently.
- raddr1 = raddr2 returns identical data on both ports.
REQ-019 Write and read to the same nonzero address in the same cycle SHALL return the old value on the read ports.
- Applies when BYPASS_EN is undefined; see REQ-025.
REQ-020 X or unused address bits SHALL NOT corrupt registers other than the decoded target.

Reset
REQ-021 rst=1 at a rising clk edge SHALL clear all NREGS registers to 0.
- Consequently rdata1 = rdata2 = 0 for any address after that edge.
REQ-022 rst SHALL take priority over we.
- A write coincident with reset is discarded.
REQ-023 Reset asserted mid-sequence SHALL discard all prior writes.
- No partial state is retained.

Configuration
REQ-024 Macro REG_FILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-025 With REG_FILE_BYPASS_EN defined, a read port SHALL return wdata in the same cycle when all of the following hold:
- we=1
- waddr != 0
- raddrN = waddr
REQ-026 With REG_FILE_BYPASS_EN undefined, no forwarding SHALL exist.
- Reads return stored register contents only, per REQ-019.

Structure
REQ-027 The shared package SHALL hold the following:
- DATA_W and ADDR_W defaults
- NREGS
- ZERO_REG = 0 constant
REQ-028 The write-strobe decoder SHALL be a sub-module named wr_decoder.
- Inputs: we, waddr.
- Output: NREGS-bit one-hot strobe, with bit 0 forced to 0.
REQ-029 Read selection SHALL be implemented as two NREGS:1 multiplexers built from the team's existing mux primitives or equivalent.

Verification
REQ-030 Reset clears registers:
- Stimulus: write 0xDEADBEEF to r5, then rst=1 for 1 cycle.
- Required response: raddr1=5 reads 0x00000000.
REQ-031 Basic write/read:
- Stimulus: we=1, waddr=7, wdata=0x12345678; next cycle raddr1=7, raddr2=7.
- Required response: both rdata ports read 0x12345678.
REQ-032 Zero register:
- Stimulus: we=1, waddr=0, wdata=0xFFFFFFFF.
- Required response: raddr1=0 reads 0x00000000 in that cycle and all later cycles.
REQ-033 Write disabled:
- Stimulus: r9=0x00000011, then we=0, waddr=9, wdata=0x00000022.
- Required response: r9 still reads 0x00000011.
REQ-034 Same-cycle read/write:
- Stimulus: r3=0x0000AAAA; we=1, waddr=3, wdata=0x0000BBBB, raddr1=3.
- Required response without BYPASS_EN: rdata1=0x0000AAAA in that cycle.
- Required response with BYPASS_EN: rdata1=0x0000BBBB in that cycle.
- Next cycle, either build: rdata1=0x0000BBBB.
REQ-035 Reset priority:
- Stimulus: rst=1 and we=1, waddr=4, wdata=0x00000055 on the same edge.
- Required response: r4 reads 0x00000000.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants for the register file: default widths, register count and the hardwired zero index.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int NREGS      = 2 ** DEF_ADDR_W;
  localparam int ZERO_REG   = 0;

endpackage : reg_file_pkg

// File: rtl/reg_file_wr_decoder.sv
// Write-strobe decoder: turns waddr into a one-hot strobe qualified by we.
// Bit 0 is never set, so writes to the zero register are dropped here.
module wr_decoder
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  output logic [2**ADDR_W-1:0] strobe
);

  always_comb begin
    strobe = '0;
    if (we) begin
      strobe[waddr] = 1'b1;
    end
    strobe[ZERO_REG] = 1'b0;
  end

endmodule : wr_decoder

// File: rtl/reg_file.sv
// Register file: one write port, two combinational read ports, register 0 reads as zero.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int NR = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [NR-1:0]     strobe;
  logic [DATA_W-1:0] regs [NR];

  wr_decoder #(
    .ADDR_W(ADDR_W)
  ) u_wr_decoder (
    .we    (we),
    .waddr (waddr),
    .strobe(strobe)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (strobe[i]) begin
          regs[i] <= wdata;
        end
      end
    end
  end

  // Zero index is masked at the mux so r0 reads 0 even before the first reset.
  always_comb begin
    rdata1 = '0;
    if (raddr1 != ZERO_ADDR) begin
      rdata1 = regs[raddr1];
    end
`ifdef REG_FILE_BYPASS_EN
    if (we && (waddr != ZERO_ADDR) && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end
`endif
  end

  always_comb begin
    rdata2 = '0;
    if (raddr2 != ZERO_ADDR) begin
      rdata2 = regs[raddr2];
    end
`ifdef REG_FILE_BYPASS_EN
    if (we && (waddr != ZERO_ADDR) && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end
`endif
  end

endmodule : reg_file
